// File: rtl/hash_result_checker.sv
// Data-memory initiator: reads NUM_WORDS result words, checks non-zero and pairwise distinct, writes one status word.
// Optional macro HASH_CHK_SIG_EN adds a rotate-xor signature output folded into status bits [23:8].
module hash_result_checker #(
    parameter logic [31:0] BASE_ADDR   = 32'h300,
    parameter int          NUM_WORDS   = 5,
    parameter logic [31:0] STATUS_ADDR = 32'h314
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          d_mem_addr,
    output logic [31:0]          d_mem_wdata,
    output logic [3:0]           d_mem_wen,
    input  logic [31:0]          d_mem_rdata,
    output logic [NUM_WORDS-1:0] nonzero_ok,
    output logic                 unique_ok,
`ifdef HASH_CHK_SIG_EN
    output logic [31:0]          sig,
`endif
    output logic                 all_pass
);

    localparam int IW = $clog2(NUM_WORDS + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CMP, S_WRITE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        j_q, j_d;
    logic [31:0]          res_q [NUM_WORDS];
    logic [31:0]          res_d [NUM_WORDS];
    logic [NUM_WORDS-1:0] nz_q, nz_d;
    logic                 uq_q, uq_d;
    logic                 ap_q, ap_d;
    logic [31:0]          cur_word, j_word, status;
`ifdef HASH_CHK_SIG_EN
    logic [31:0]          sig_q, sig_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            j_q     <= '0;
            nz_q    <= '0;
            uq_q    <= 1'b0;
            ap_q    <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) res_q[i] <= '0;
`ifdef HASH_CHK_SIG_EN
            sig_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            nz_q    <= nz_d;
            uq_q    <= uq_d;
            ap_q    <= ap_d;
            for (int i = 0; i < NUM_WORDS; i++) res_q[i] <= res_d[i];
`ifdef HASH_CHK_SIG_EN
            sig_q   <= sig_d;
`endif
        end
    end

    // Buffer muxes for the word being checked (idx) and the earlier word it is compared against (j).
    always_comb begin
        cur_word = '0;
        j_word   = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (idx_q == IW'(i)) cur_word = res_q[i];
            if (j_q == IW'(i))   j_word   = res_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        j_d     = j_q;
        nz_d    = nz_q;
        uq_d    = uq_q;
        ap_d    = ap_q;
        for (int i = 0; i < NUM_WORDS; i++) res_d[i] = res_q[i];
`ifdef HASH_CHK_SIG_EN
        sig_d   = sig_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    j_d     = '0;
                    nz_d    = '0;
                    uq_d    = 1'b1;
                    ap_d    = 1'b0;
`ifdef HASH_CHK_SIG_EN
                    sig_d   = '0;
`endif
                    state_d = S_READ;
                end
            end
            S_READ: begin
                for (int i = 0; i < NUM_WORDS; i++) begin
                    if (idx_q == IW'(i)) begin
                        res_d[i] = d_mem_rdata;
                        nz_d[i]  = |d_mem_rdata;
                    end
                end
`ifdef HASH_CHK_SIG_EN
                sig_d = {sig_q[26:0], sig_q[31:27]} ^ d_mem_rdata;
`endif
                ap_d = (&nz_d) & uq_q;
                if (idx_q == '0) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = (NUM_WORDS == 1) ? S_WRITE : S_READ;
                end else begin
                    j_d     = '0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (cur_word == j_word) uq_d = 1'b0;
                ap_d = (&nz_q) & uq_d;
                if (j_q == idx_q - IW'(1)) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = (idx_q == LAST) ? S_WRITE : S_READ;
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        status                = '0;
        status[31]            = ap_q;
        status[30]            = uq_q;
        status[NUM_WORDS-1:0] = nz_q;
`ifdef HASH_CHK_SIG_EN
        status[23:8]          = sig_q[15:0];
`endif
        d_mem_addr  = '0;
        d_mem_wdata = '0;
        d_mem_wen   = 4'b0000;
        if (state_q == S_READ) begin
            d_mem_addr = BASE_ADDR + (32'(idx_q) << 2);
        end else if (state_q == S_WRITE) begin
            d_mem_addr  = STATUS_ADDR;
            d_mem_wdata = status;
            d_mem_wen   = 4'b1111;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign nonzero_ok = nz_q;
    assign unique_ok  = uq_q;
    assign all_pass   = ap_q;
`ifdef HASH_CHK_SIG_EN
    assign sig        = sig_q;
`endif

endmodule

// File: tb/tb_hash_result_checker.sv
// Directed bench: a 5-word instance against a vector table plus corner sequences, and a 1-word instance.
module tb_hash_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic        busy, done, busy2, done2;
    logic [31:0] addr, wdata, rdata, addr2, wdata2, rdata2;
    logic [3:0]  wen, wen2;
    logic [4:0]  nz;
    logic [0:0]  nz2;
    logic        uq, ap, uq2, ap2;
`ifdef HASH_CHK_SIG_EN
    logic [31:0] sig, sig2;
    localparam logic [31:0] ST_MASK = 32'hC00000FF;
`else
    localparam logic [31:0] ST_MASK = 32'hFFFFFFFF;
`endif

    logic [31:0] mem [5];
    logic [31:0] mem2;
    int errs = 0, checks = 0;
    int wr_cnt = 0, wr2_cnt = 0;
    logic [31:0] wr_addr, wr_data, wr2_addr, wr2_data;

    always #5 clk = ~clk;

    hash_result_checker dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .d_mem_addr(addr), .d_mem_wdata(wdata), .d_mem_wen(wen), .d_mem_rdata(rdata),
        .nonzero_ok(nz), .unique_ok(uq),
`ifdef HASH_CHK_SIG_EN
        .sig(sig),
`endif
        .all_pass(ap)
    );

    hash_result_checker #(.NUM_WORDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .d_mem_addr(addr2), .d_mem_wdata(wdata2), .d_mem_wen(wen2), .d_mem_rdata(rdata2),
        .nonzero_ok(nz2), .unique_ok(uq2),
`ifdef HASH_CHK_SIG_EN
        .sig(sig2),
`endif
        .all_pass(ap2)
    );

    always_comb begin
        logic [31:0] off;
        off   = addr - 32'h300;
        rdata = '0;
        if (addr >= 32'h300 && addr < 32'h314) rdata = mem[off[4:2]];
    end
    assign rdata2 = (addr2 == 32'h300) ? mem2 : 32'h0;

    always @(posedge clk) begin
        if (wen != 4'b0000) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= addr;
            wr_data <= wdata;
        end
        if (wen2 != 4'b0000) begin
            wr2_cnt  <= wr2_cnt + 1;
            wr2_addr <= addr2;
            wr2_data <= wdata2;
        end
    end

    typedef struct {
        logic [4:0][31:0] w;
        logic [4:0]       nz;
        logic             uq;
        logic             ap;
        logic [31:0]      st;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one transaction on the 5-word instance; hold keeps start high until done is seen.
    task automatic run_vec(input string tag, input vec_t v, input bit hold);
        int n;
        int base;
        for (int i = 0; i < 5; i++) mem[i] = v.w[i];
        base = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done_edge"}, 32'(n), 32'd16);
        check({tag, " wen_count"}, 32'(wr_cnt - base), 32'd1);
        check({tag, " wr_addr"}, wr_addr, 32'h314);
        check({tag, " status"}, wr_data & ST_MASK, v.st & ST_MASK);
        check({tag, " nonzero_ok"}, 32'(nz), 32'(v.nz));
        check({tag, " unique_ok"}, 32'(uq), 32'(v.uq));
        check({tag, " all_pass"}, 32'(ap), 32'(v.ap));
        repeat (3) @(negedge clk);
        check({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
        check({tag, " no_rerun"}, 32'(wr_cnt - base), 32'd1);
    endtask

    vec_t vecs [3];

    initial begin
        int base;
        int n;
        vec_t v;
        vecs[0] = '{w: {32'h55, 32'h44, 32'h33, 32'h22, 32'h11},
                    nz: 5'h1F, uq: 1'b1, ap: 1'b1, st: 32'hC000001F};
        vecs[1] = '{w: {32'h55, 32'h44, 32'h0, 32'h22, 32'h11},
                    nz: 5'b11011, uq: 1'b1, ap: 1'b0, st: 32'h4000001B};
        vecs[2] = '{w: {32'h5, 32'hABCD, 32'h3, 32'h2, 32'hABCD},
                    nz: 5'h1F, uq: 1'b0, ap: 1'b0, st: 32'h0000001F};

        rst = 1'b1; start = 1'b0; start2 = 1'b0; mem2 = '0;
        for (int i = 0; i < 5; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check("reset busy_done", {30'd0, busy, done}, 32'd0);
        check("reset addr", addr, 32'd0);
        check("reset wdata", wdata, 32'd0);
        check("reset wen", 32'(wen), 32'd0);
        check("reset flags", {25'd0, nz, uq, ap}, 32'd0);
`ifdef HASH_CHK_SIG_EN
        check("reset sig", sig, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 3; k++) run_vec($sformatf("vec%0d", k), vecs[k], 1'b0);

        run_vec("held_start", vecs[0], 1'b1);

        // Abort a run while comparing: outputs drop at once and no status write follows.
        for (int i = 0; i < 5; i++) mem[i] = vecs[0].w[i];
        base = wr_cnt;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrun busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrun busy_done", {30'd0, busy, done}, 32'd0);
        check("midrun flags", {25'd0, nz, uq, ap}, 32'd0);
        check("midrun addr_wen", addr | 32'(wen), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrun no_write", 32'(wr_cnt - base), 32'd0);
        run_vec("after_reset", vecs[0], 1'b0);

`ifdef HASH_CHK_SIG_EN
        v = '{w: {32'h5, 32'h4, 32'h3, 32'h2, 32'h1},
              nz: 5'h1F, uq: 1'b1, ap: 1'b1, st: 32'hC000001F};
        run_vec("sig_run", v, 1'b0);
        check("sig value", sig, 32'h00110C85);
        check("sig status", wr_data, 32'hC00C851F);
`else
        v = vecs[0];
`endif

        // Single-word instance: no compare cycles at all.
        mem2 = 32'h7;
        base = wr2_cnt;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("one_word done_edge", 32'(n), 32'd2);
        check("one_word wen_count", 32'(wr2_cnt - base), 32'd1);
        check("one_word wr_addr", wr2_addr, 32'h314);
        check("one_word status", wr2_data & ST_MASK, 32'hC0000001 & ST_MASK);
        check("one_word flags", {29'd0, nz2, uq2, ap2}, 32'h7);
`ifdef HASH_CHK_SIG_EN
        check("one_word sig", sig2, 32'h7);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
